// File: rtl/basicgates_bist.sv
// Built-in self-test around the basicgates two-input gate block: walks {a,b}
// through 00..11, checks all six gate outputs and reports pass/fail details.
//
// state | meaning
// IDLE  | waiting for start; results from the last run held
// DRIVE | current vector on a/b, waiting HOLD_CYCLES edges for outputs to settle
// CHECK | compare gate outputs against expected, then advance vector or finish
// DONE  | one-cycle done pulse, pass resolved
module basicgates_bist #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       andc,
    input  logic       orc,
    input  logic       nandc,
    input  logic       norc,
    input  logic       xorc,
    input  logic       xnorc,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] fail_vec,
    output logic [5:0] fail_mask,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] vec, vec_nxt, vec_inc;
    logic [3:0] hold, hold_nxt;
    logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [1:0] fail_vec_nxt;
    logic [5:0] fail_mask_nxt, expected, actual, mism;
    logic [2:0] err_count_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 2'd0;
            hold      <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= 2'd0;
            fail_mask <= 6'd0;
            err_count <= 3'd0;
        end else begin
            state     <= state_nxt;
            vec       <= vec_nxt;
            hold      <= hold_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            fail_vec  <= fail_vec_nxt;
            fail_mask <= fail_mask_nxt;
            err_count <= err_count_nxt;
        end
    end

    // Expected values come from the registered a/b actually being driven.
    assign expected = {a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    assign actual   = {andc, orc, nandc, norc, xorc, xnorc};
    assign mism     = actual ^ expected;
    assign vec_inc  = vec + 2'd1;

    always_comb begin
        state_nxt     = state;
        vec_nxt       = vec;
        hold_nxt      = hold;
        a_nxt         = a;
        b_nxt         = b;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        pass_nxt      = pass;
        fail_vec_nxt  = fail_vec;
        fail_mask_nxt = fail_mask;
        err_count_nxt = err_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = DRIVE;
                    vec_nxt       = 2'd0;
                    hold_nxt      = 4'd0;
                    a_nxt         = 1'b0;
                    b_nxt         = 1'b0;
                    busy_nxt      = 1'b1;
                    pass_nxt      = 1'b0;
                    fail_vec_nxt  = 2'd0;
                    fail_mask_nxt = 6'd0;
                    err_count_nxt = 3'd0;
                end
            end
            DRIVE: begin
                hold_nxt = hold + 4'd1;
                if (hold == HOLD_LAST) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (mism != 6'd0) begin
                    err_count_nxt = err_count + 3'd1;
                    if (err_count == 3'd0) begin
                        fail_vec_nxt  = vec;
                        fail_mask_nxt = mism;
                    end
                end
                if (vec != 2'd3) begin
                    state_nxt = DRIVE;
                    vec_nxt   = vec_inc;
                    a_nxt     = vec_inc[1];
                    b_nxt     = vec_inc[0];
                    hold_nxt  = 4'd0;
                end else begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_count_nxt == 3'd0);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_basicgates_bist.sv
// Self-checking bench for basicgates_bist: behavioural gate block with
// injectable faults, two DUT instances (HOLD_CYCLES=2 and 1).
module tb_basicgates_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a, b, busy, done, pass;
        logic [1:0] fv;
        logic [5:0] fm;
        logic [2:0] ec;
    } obs_t;

    typedef struct {
        int         fault;
        logic       exp_pass;
        logic [1:0] exp_vec;
        logic [5:0] exp_mask;
        logic [2:0] exp_err;
        string      name;
    } run_t;

    logic       rst2, start2, a2, b2, busy2, done2, pass2;
    logic [1:0] fv2;
    logic [5:0] fm2, g2;
    logic [2:0] ec2;
    int         fault2;

    logic       rst1, start1, a1, b1, busy1, done1, pass1;
    logic [1:0] fv1;
    logic [5:0] fm1, g1;
    logic [2:0] ec1;
    int         fault1;

    int checks = 0;
    int errors = 0;

    // fault 1: xor stuck-at-0, 2: nand/nor swapped, 3: and stuck-at-1
    function automatic logic [5:0] gates(input logic x, input logic y, input int f);
        logic [5:0] g;
        g = {x & y, x | y, ~(x & y), ~(x | y), x ^ y, ~(x ^ y)};
        if (f == 1) g[1] = 1'b0;
        if (f == 2) g = {g[5:4], g[2], g[3], g[1:0]};
        if (f == 3) g[5] = 1'b1;
        return g;
    endfunction

    always_comb g2 = gates(a2, b2, fault2);
    always_comb g1 = gates(a1, b1, fault1);

    basicgates_bist #(.HOLD_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2),
        .andc(g2[5]), .orc(g2[4]), .nandc(g2[3]), .norc(g2[2]), .xorc(g2[1]), .xnorc(g2[0]),
        .busy(busy2), .done(done2), .pass(pass2),
        .fail_vec(fv2), .fail_mask(fm2), .err_count(ec2)
    );

    basicgates_bist #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .andc(g1[5]), .orc(g1[4]), .nandc(g1[3]), .norc(g1[2]), .xorc(g1[1]), .xnorc(g1[0]),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1), .fail_mask(fm1), .err_count(ec1)
    );

    function automatic obs_t observe(input int sel);
        obs_t o;
        if (sel == 1) begin
            o.a = a1; o.b = b1; o.busy = busy1; o.done = done1; o.pass = pass1;
            o.fv = fv1; o.fm = fm1; o.ec = ec1;
        end else begin
            o.a = a2; o.b = b2; o.busy = busy2; o.done = done2; o.pass = pass2;
            o.fv = fv2; o.fm = fm2; o.ec = ec2;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int sel, input string tag);
        obs_t o;
        o = observe(sel);
        chk({tag, " ab"}, 8'({o.a, o.b}), 8'd0);
        chk({tag, " busy"}, 8'(o.busy), 8'd0);
        chk({tag, " done"}, 8'(o.done), 8'd0);
        chk({tag, " pass"}, 8'(o.pass), 8'd0);
        chk({tag, " fail_vec"}, 8'(o.fv), 8'd0);
        chk({tag, " fail_mask"}, 8'(o.fm), 8'd0);
        chk({tag, " err_count"}, 8'(o.ec), 8'd0);
    endtask

    // One start pulse, then follow the run edge by edge until done.
    task automatic do_run(input int sel, input int hold, input logic exp_pass,
                          input logic [1:0] exp_vec, input logic [5:0] exp_mask,
                          input logic [2:0] exp_err, input string tag);
        obs_t o;
        int   j;
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        step();
        if (sel == 1) start1 = 1'b0; else start2 = 1'b0;
        j = 0;
        o = observe(sel);
        while (!o.done && j < 40) begin
            chk({tag, " ab seq"}, 8'({o.a, o.b}), 8'(j / (hold + 1)));
            chk({tag, " busy in run"}, 8'(o.busy), 8'd1);
            step();
            j++;
            o = observe(sel);
        end
        chk({tag, " done latency"}, 8'(j), 8'(4 * (hold + 1)));
        chk({tag, " done"}, 8'(o.done), 8'd1);
        chk({tag, " busy at done"}, 8'(o.busy), 8'd0);
        chk({tag, " pass"}, 8'(o.pass), 8'(exp_pass));
        chk({tag, " fail_vec"}, 8'(o.fv), 8'(exp_vec));
        chk({tag, " fail_mask"}, 8'(o.fm), 8'(exp_mask));
        chk({tag, " err_count"}, 8'(o.ec), 8'(exp_err));
        chk({tag, " ab after"}, 8'({o.a, o.b}), 8'd3);
        step();
        o = observe(sel);
        chk({tag, " done pulse"}, 8'(o.done), 8'd0);
        chk({tag, " pass held"}, 8'(o.pass), 8'(exp_pass));
        chk({tag, " err held"}, 8'(o.ec), 8'(exp_err));
        chk({tag, " ab held"}, 8'({o.a, o.b}), 8'd3);
    endtask

    run_t runs[4];

    initial begin
        obs_t o;
        int   dones;
        logic exp_b, exp_d;

        runs[0] = '{0, 1'b1, 2'd0, 6'b000000, 3'd0, "good"};
        runs[1] = '{1, 1'b0, 2'd1, 6'b000010, 3'd2, "xor_sa0"};
        runs[2] = '{2, 1'b0, 2'd1, 6'b001100, 3'd2, "nand_nor_swap"};
        runs[3] = '{3, 1'b0, 2'd0, 6'b100000, 3'd3, "and_sa1"};

        rst2 = 1'b1; rst1 = 1'b1; start2 = 1'b0; start1 = 1'b0;
        fault2 = 0; fault1 = 0;
        step();
        step();
        chk_reset(0, "reset h2");
        chk_reset(1, "reset h1");
        rst2 = 1'b0; rst1 = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            fault2 = runs[i].fault;
            do_run(0, 2, runs[i].exp_pass, runs[i].exp_vec, runs[i].exp_mask,
                   runs[i].exp_err, runs[i].name);
        end

        fault1 = 0;
        do_run(1, 1, 1'b1, 2'd0, 6'd0, 3'd0, "hold1");

        // start held high: relaunch on the first edge back in IDLE
        fault2 = 1;
        start2 = 1'b1;
        dones = 0;
        for (int j = 0; j < 30; j++) begin
            step();
            o = observe(0);
            exp_d = (j == 12 || j == 26);
            exp_b = !(j == 12 || j == 13 || j == 26 || j == 27);
            if (o.done) dones++;
            chk("held busy", 8'(o.busy), 8'(exp_b));
            chk("held done", 8'(o.done), 8'(exp_d));
            if (j == 13) chk("held err before relaunch", 8'(o.ec), 8'd2);
            if (j == 14) begin
                chk("held err cleared", 8'(o.ec), 8'd0);
                chk("held pass cleared", 8'(o.pass), 8'd0);
            end
        end
        start2 = 1'b0;
        chk("held done count", 8'(dones), 8'd2);
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        fault2 = 0;
        step();

        // reset while vector 2 is being driven
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int j = 1; j <= 6; j++) step();
        o = observe(0);
        chk("midrst ab before", 8'({o.a, o.b}), 8'd2);
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        chk_reset(0, "midrst");
        dones = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (done2) dones++;
        end
        chk("midrst no done", 8'(dones), 8'd0);
        do_run(0, 2, 1'b1, 2'd0, 6'd0, 3'd0, "after midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/basicgates_bist.md
Name: basicgates_bist

Overview:
- Self-checking stimulus/response stage wrapped around the basicgates two-input gate block.
- Drives basicgates `a`/`b` inputs through all four input vectors (00, 01, 10, 11).
- Consumes the six gate outputs for each vector and compares them against internally computed expected values.
- Reports pass/fail, the first failing vector, the mismatching-gate mask and the failure count. Intended as the on-chip/bench replacement for hand-written stimulus around basicgates.

Parameters:
- HOLD_CYCLES, 2, cycles each vector is driven before its outputs are sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request a test run; sampled only in IDLE.
- a  output  1  operand A driven to basicgates.
- b  output  1  operand B driven to basicgates.
- andc  input  1  AND result from basicgates.
- orc  input  1  OR result from basicgates.
- nandc  input  1  NAND result from basicgates.
- norc  input  1  NOR result from basicgates.
- xorc  input  1  XOR result from basicgates.
- xnorc  input  1  XNOR result from basicgates.
- busy  output  1  run in progress (DRIVE or CHECK).
- done  output  1  one-cycle pulse: run complete, results valid.
- pass  output  1  1 = all four vectors matched; valid from done until the next start or reset.
- fail_vec  output  2  {a,b} of the first failing vector; 0 if none.
- fail_mask  output  6  gates mismatching at the first failing vector. Bit order: [5]and [4]or [3]nand [2]nor [1]xor [0]xnor.
- err_count  output  3  number of failing vectors, 0..4.

Behaviour:
- Reset (rst=1 at a rising edge, regardless of state), all registered:
  - state=IDLE, a=b=0.
  - busy=done=pass=0, fail_vec=0, fail_mask=0, err_count=0.
- States: IDLE, DRIVE, CHECK, DONE.
  - The 2-bit vector index vec drives {a,b}={vec[1],vec[0]}.
  - `a` and `b` are registered and change only on entry to DRIVE.
- IDLE:
  - start=1 at an edge moves to DRIVE with vec=0 and hold counter=0.
  - The same edge clears pass, fail_vec, fail_mask and err_count.
- DRIVE:
  - Hold counter increments each edge.
  - After HOLD_CYCLES edges in DRIVE, move to CHECK.
- CHECK, one cycle; at the exiting edge, gate inputs are compared with expected values:
  - Expected: a&b, a|b, ~(a&b), ~(a|b), a^b, ~(a^b).
  - Mismatch: err_count += 1.
  - Mismatch and err_count was 0: latch fail_vec=vec and fail_mask=per-gate XOR of actual vs expected.
  - vec<3: vec+1, update a/b, return to DRIVE with hold counter=0.
  - vec==3: go to DONE.
- DONE, one cycle:
  - done=1.
  - pass=1 if err_count==0 and stays 1 afterward; pass stays 0 otherwise.
  - Next state is IDLE unconditionally.
- Timing:
  - Each vector occupies HOLD_CYCLES+1 cycles.
  - With start sampled at edge E0, done is high during the cycle following edge E0+4*(HOLD_CYCLES+1).
  - busy is high from E0 until the edge that enters DONE.
  - Default: done is high 12 edges after start.
- start is ignored in DRIVE, CHECK and DONE. A held-high start relaunches only after returning to IDLE, i.e. the first edge in IDLE.
- err_count saturation is not needed: the maximum is 4 and fits 3 bits.
- After DONE:
  - a and b keep the last vector (11) until the next start or reset.
  - Results hold until the next start or reset.
- Reset mid-run:
  - Abort on the reset edge; all outputs take reset values.
  - No done pulse is generated.
- Gate inputs are treated as plain 0/1.

Test Plan:
1. Correct basicgates attached, HOLD_CYCLES=2, one-cycle start pulse:
   - {a,b} = 00, 01, 10, 11, each held for 3 cycles.
   - done pulses 12 edges after start; pass=1, err_count=0, fail_vec=0, fail_mask=0.
2. xorc forced stuck-at-0:
   - Vectors 01 and 10 fail.
   - Result: fail_vec=01, fail_mask=000010, err_count=2, pass=0.
3. nandc and norc wires swapped:
   - Vector 00 passes; vectors 01 and 10 fail; vector 11 passes.
   - Result: fail_vec=01, fail_mask=001100, err_count=2, pass=0.
4. start held high for 30 cycles:
   - busy never deasserts mid-run; exactly one done per run.
   - Second run starts on the edge after DONE, and err_count/pass are cleared on that edge.
5. rst asserted for one cycle while vec=2 is in DRIVE:
   - Next cycle: a=b=0, busy=0, done=0, pass=0, err_count=0.
   - No done pulse follows.
   - A later start produces a full clean run.
6. HOLD_CYCLES=1, correct basicgates:
   - Each vector is held 2 cycles.
   - done pulses 8 edges after start; pass=1.
